// File: rtl/memory_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// memory_stage : data memory access, stack sequencing and branch resolution
// Revision 1.0
// ---------------------------------------------------------------------------
module memory_stage #(
   parameter int                ADDR_W  = 12,
   parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [105:0]      in_i,
   output logic [20:0]       out_o,
   output logic [19:0]       fwd_o,
   output logic              stall_o,
   output logic              pc_load_o,
   output logic [31:0]       pc_target_o,
   output logic              flags_load_o,
   output logic [2:0]        flags_val_o,
   output logic [ADDR_W-1:0] sp_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      C_HI  = 2'd1,
      R_LO  = 2'd2,
      I_FLG = 2'd3
   } state_t;

   state_t            state_q;
   logic [15:0]       mem_q [0:(1<<ADDR_W)-1];
   logic [ADDR_W-1:0] sp_q;
   logic [20:0]       out_q;
   logic              pc_load_q;
   logic [31:0]       pc_target_q;
   logic              flags_load_q;
   logic [2:0]        flags_val_q;
   logic [15:0]       lo_q;
   logic [15:0]       tgt_q;
   logic [2:0]        flags_cap_q;
   logic              rti_q;

   logic [15:0]       alu, rsrc, inport, data, top, wdata;
   logic [31:0]       nextpc;
   logic [ADDR_W-1:0] addr, sp_inc, sp_dec, waddr;
   logic              idle, taken, multi, we;
   logic              op_call, op_rti, op_ret, op_push, op_pop, op_ldd, op_std, op_in, op_out;
   logic              unused_bits;

   assign alu         = in_i[34:19];
   assign rsrc        = in_i[50:35];
   assign nextpc      = in_i[82:51];
   assign inport      = in_i[98:83];
   assign addr        = alu[ADDR_W-1:0];
   assign sp_inc      = sp_q + ADDR_W'(1);
   assign sp_dec      = sp_q - ADDR_W'(1);
   assign top         = mem_q[sp_inc];
   assign idle        = (state_q == IDLE);
   assign taken       = in_i[102] | (in_i[101] & in_i[105]) | (in_i[100] & in_i[104]) | (in_i[99] & in_i[103]);
   assign unused_bits = ^{in_i[18:16], in_i[12], in_i[4], in_i[2]};

   // One-hot decode in priority order; lower-priority bits are ignored when several are set
   always_comb begin
      op_call = 1'b0; op_rti = 1'b0; op_ret = 1'b0; op_push = 1'b0; op_pop = 1'b0;
      op_ldd  = 1'b0; op_std = 1'b0; op_in  = 1'b0; op_out  = 1'b0;
      if      (in_i[3])  op_call = 1'b1;
      else if (in_i[8])  op_rti  = 1'b1;
      else if (in_i[9])  op_ret  = 1'b1;
      else if (in_i[11]) op_push = 1'b1;
      else if (in_i[10]) op_pop  = 1'b1;
      else if (in_i[7])  op_ldd  = 1'b1;
      else if (in_i[1])  op_std  = 1'b1;
      else if (in_i[6])  op_in   = 1'b1;
      else if (in_i[5])  op_out  = 1'b1;
   end

   assign multi = op_call | op_ret | op_rti;

   always_comb begin
      data = alu;
      if      (op_pop) data = top;
      else if (op_ldd) data = mem_q[addr];
      else if (op_in)  data = inport;
      else if (op_out) data = rsrc;
   end

   assign fwd_o   = {in_i[0] & ~multi, in_i[15:13], data};
   assign stall_o = (idle & multi) | (state_q == I_FLG);

   always_comb begin
      we    = 1'b0;
      waddr = sp_q;
      wdata = rsrc;
      if (idle) begin
         if (op_call) begin
            we    = 1'b1;
            wdata = nextpc[31:16];
         end else if (op_push) begin
            we = 1'b1;
         end else if (op_std) begin
            we    = 1'b1;
            waddr = addr;
         end
      end else if (state_q == C_HI) begin
         we    = 1'b1;
         wdata = lo_q;
      end
   end

   // Writes are suppressed while reset is held so an aborted sequence leaves no trace
   always_ff @(posedge clk_i) begin
      if (we && !rst_i) mem_q[waddr] <= wdata;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         sp_q         <= SP_INIT;
         out_q        <= '0;
         pc_load_q    <= 1'b0;
         pc_target_q  <= '0;
         flags_load_q <= 1'b0;
         flags_val_q  <= '0;
         lo_q         <= '0;
         tgt_q        <= '0;
         flags_cap_q  <= '0;
         rti_q        <= 1'b0;
      end else begin
         pc_load_q    <= 1'b0;
         flags_load_q <= 1'b0;
         out_q        <= stall_o ? '0 : {fwd_o[19:16], op_out, data};
         case (state_q)
            IDLE: begin
               if (op_call) begin
                  sp_q    <= sp_dec;
                  lo_q    <= nextpc[15:0];
                  tgt_q   <= alu;
                  state_q <= C_HI;
               end else if (op_rti) begin
                  flags_cap_q <= top[2:0];
                  sp_q        <= sp_inc;
                  rti_q       <= 1'b1;
                  state_q     <= I_FLG;
               end else if (op_ret) begin
                  lo_q    <= top;
                  sp_q    <= sp_inc;
                  rti_q   <= 1'b0;
                  state_q <= R_LO;
               end else begin
                  if (op_push)     sp_q <= sp_dec;
                  else if (op_pop) sp_q <= sp_inc;
                  if (taken) begin
                     pc_load_q   <= 1'b1;
                     pc_target_q <= {16'h0, alu};
                  end
               end
            end
            C_HI: begin
               sp_q        <= sp_dec;
               pc_load_q   <= 1'b1;
               pc_target_q <= {16'h0, tgt_q};
               state_q     <= IDLE;
            end
            I_FLG: begin
               lo_q    <= top;
               sp_q    <= sp_inc;
               state_q <= R_LO;
            end
            default: begin
               sp_q        <= sp_inc;
               pc_load_q   <= 1'b1;
               pc_target_q <= {top, lo_q};
               if (rti_q) begin
                  flags_load_q <= 1'b1;
                  flags_val_q  <= flags_cap_q;
               end
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign out_o        = out_q;
   assign pc_load_o    = pc_load_q;
   assign pc_target_o  = pc_target_q;
   assign flags_load_o = flags_load_q;
   assign flags_val_o  = flags_val_q;
   assign sp_o         = sp_q;

endmodule
`default_nettype wire
